// File: rtl/cmd_pkg.sv
// cmd_pkg: shared FSM states, opcode constants and response codes for the command sender.
package cmd_pkg;

    typedef enum logic [1:0] {IDLE, TX_HI, TX_LO, WAIT_RESP} state_t;

    localparam logic [2:0] CAL  = 3'b000;
    localparam logic [2:0] HDNG = 3'b001;
    localparam logic [2:0] MOVE = 3'b010;
    localparam logic [2:0] SOLV = 3'b011;

    localparam logic [7:0] POS_ACK = 8'hA5;

endpackage

// File: rtl/cmd_sndr.sv
// cmd_sndr: sends a 16-bit command as two UART bytes (high first) and waits for a one-byte
// response or a timeout.
module cmd_sndr
    import cmd_pkg::*;
#(
    parameter logic [23:0] TMO_CYC = 24'd10_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] cmd,
    input  logic        snd_cmd,
    output logic        cmd_snt,
    output logic        trmt,
    output logic [7:0]  tx_data,
    input  logic        tx_done,
    input  logic        rx_rdy,
    input  logic [7:0]  rx_data,
    output logic        clr_rx_rdy,
    output logic [7:0]  resp,
    output logic        resp_rdy,
    output logic        ack,
    output logic        busy,
    output logic        tmo
);

    state_t      state, nxt;
    logic [15:0] held;
    logic [23:0] cnt;
    logic        trmt_q, clr_q;

    always_comb begin
        nxt        = state;
        trmt       = 1'b0;
        cmd_snt    = 1'b0;
        tmo        = 1'b0;
        clr_rx_rdy = rx_rdy & ~clr_q & ~rst;
        if (!rst) begin
            case (state)
                IDLE:      if (snd_cmd) begin trmt = 1'b1; nxt = TX_HI; end
                TX_HI:     if (tx_done && !trmt_q) begin trmt = 1'b1; nxt = TX_LO; end
                TX_LO:     if (tx_done) begin cmd_snt = 1'b1; nxt = WAIT_RESP; end
                WAIT_RESP: if (clr_rx_rdy) nxt = IDLE;
                           else if (cnt == TMO_CYC - 24'd1) begin tmo = 1'b1; nxt = IDLE; end
                default:   nxt = IDLE;
            endcase
        end
        // high byte stays on the bus through TX_HI until the low byte is actually loaded
        tx_data = (state == IDLE) ? cmd[15:8] :
                  (state == TX_HI && !trmt) ? held[15:8] : held[7:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            held     <= '0;
            cnt      <= '0;
            resp     <= '0;
            resp_rdy <= 1'b0;
            trmt_q   <= 1'b0;
            clr_q    <= 1'b0;
        end else begin
            state  <= nxt;
            trmt_q <= trmt;
            clr_q  <= clr_rx_rdy;
            cnt    <= (state == WAIT_RESP) ? cnt + 24'd1 : '0;
            if (state == IDLE && snd_cmd) begin
                held     <= cmd;
                resp_rdy <= 1'b0;
            end
            if (state == WAIT_RESP && clr_rx_rdy) begin
                resp     <= rx_data;
                resp_rdy <= 1'b1;
            end
        end
    end

    assign busy = (state != IDLE);
    assign ack  = resp_rdy && (resp == POS_ACK);

endmodule

// File: tb/tb_cmd_sndr.sv
// tb_cmd_sndr: table-driven transactions against a UART model that answers each trmt with
// tx_done 20 cycles later; transmitted bytes are checked through a scoreboard queue.
module tb_cmd_sndr;
    import cmd_pkg::*;

    logic        clk = 1'b0, rst = 1'b1;
    logic [15:0] cmd = '0;
    logic        snd_cmd = 1'b0, tx_done = 1'b0, rx_rdy = 1'b0;
    logic [7:0]  rx_data = '0;
    logic        cmd_snt, trmt, clr_rx_rdy, resp_rdy, ack, busy, tmo;
    logic [7:0]  tx_data, resp;

    always #5 clk = ~clk;

    cmd_sndr #(.TMO_CYC(24'd50)) dut (
        .clk(clk), .rst(rst), .cmd(cmd), .snd_cmd(snd_cmd), .cmd_snt(cmd_snt),
        .trmt(trmt), .tx_data(tx_data), .tx_done(tx_done), .rx_rdy(rx_rdy),
        .rx_data(rx_data), .clr_rx_rdy(clr_rx_rdy), .resp(resp), .resp_rdy(resp_rdy),
        .ack(ack), .busy(busy), .tmo(tmo)
    );

    int         total = 0, bad = 0;
    logic [7:0] exp_q[$];
    int         cd = 0, snt_cnt = 0, tmo_cnt = 0, viol = 0;
    logic       nxt_done = 1'b0;
    logic [3:0] prev = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // UART model and scoreboard, sampled mid-cycle
    always @(negedge clk) begin
        if (trmt) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL extra_byte: got %0h want none", tx_data);
            end else chk("tx_byte", {24'd0, tx_data}, {24'd0, exp_q.pop_front()});
        end
        if (cd > 0) cd--;
        if (trmt) cd = 20;
        nxt_done = (cd == 1);
        snt_cnt += int'(cmd_snt);
        tmo_cnt += int'(tmo);
        viol += int'(trmt & prev[0]) + int'(cmd_snt & prev[1]) + int'(clr_rx_rdy & prev[2]) + int'(tmo & prev[3]);
        prev = {tmo, clr_rx_rdy, cmd_snt, trmt};
    end

    always @(posedge clk) begin
        #1 tx_done = nxt_done;
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    typedef struct {
        logic [15:0] c;
        int          dly;
        logic [7:0]  rb;
        logic [7:0]  er;
        logic        erdy;
        logic        eack;
        int          etmo;
    } vec_t;

    task automatic send(input logic [15:0] c);
        @(posedge clk); #1;
        cmd = c;
        snd_cmd = 1'b1;
        exp_q.push_back(c[15:8]);
        exp_q.push_back(c[7:0]);
        @(negedge clk);
        chk("trmt_on_snd", {31'd0, trmt}, 1);
        @(posedge clk); #1;
        snd_cmd = 1'b0;
    endtask

    task automatic wait_snt();
        int ok = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (cmd_snt) begin ok = 1; break; end
        end
        chk("cmd_snt_seen", ok, 1);
    endtask

    task automatic respond(input int dly, input logic [7:0] b);
        repeat (dly) begin @(posedge clk); #1; end
        rx_data = b;
        rx_rdy = 1'b1;
        @(negedge clk);
        chk("clr_on_resp", {31'd0, clr_rx_rdy}, 1);
        chk("no_tmo_on_resp", {31'd0, tmo}, 0);
        @(posedge clk); #1;
        rx_rdy = 1'b0;
    endtask

    task automatic txn(input vec_t t);
        int s0, t0, k;
        s0 = snt_cnt;
        t0 = tmo_cnt;
        send(t.c);
        wait_snt();
        chk("busy_wait", {31'd0, busy}, 1);
        if (t.dly > 0) respond(t.dly, t.rb);
        else begin
            k = 0;
            while (!tmo && k < 200) begin @(negedge clk); k++; end
            chk("tmo_latency", k, 50);
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("resp", {24'd0, resp}, {24'd0, t.er});
        chk("resp_rdy", {31'd0, resp_rdy}, {31'd0, t.erdy});
        chk("ack", {31'd0, ack}, {31'd0, t.eack});
        chk("busy_done", {31'd0, busy}, 0);
        chk("snt_pulses", snt_cnt - s0, 1);
        chk("tmo_pulses", tmo_cnt - t0, t.etmo);
    endtask

    vec_t v[5];
    int   s0;

    initial begin
        v[0] = '{16'h2A5F, 5,  8'hA5, 8'hA5, 1'b1, 1'b1, 0};
        v[1] = '{16'h1234, 0,  8'h00, 8'hA5, 1'b0, 1'b0, 1};
        v[2] = '{16'h0FFF, 50, 8'h5A, 8'h5A, 1'b1, 1'b0, 0};
        v[3] = '{16'h6C01, 49, 8'hA5, 8'hA5, 1'b1, 1'b1, 0};
        v[4] = '{16'h7E00, 1,  8'h3C, 8'h3C, 1'b1, 1'b0, 0};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_resp", {24'd0, resp}, 0);
        chk("rst_resp_rdy", {31'd0, resp_rdy}, 0);
        chk("rst_pulses", {28'd0, trmt, cmd_snt, clr_rx_rdy, tmo}, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < 5; i++) txn(v[i]);

        // stray byte in IDLE is cleared without touching resp
        @(posedge clk); #1;
        rx_data = 8'h77;
        rx_rdy = 1'b1;
        @(negedge clk);
        chk("discard_clr", {31'd0, clr_rx_rdy}, 1);
        @(posedge clk); #1;
        rx_rdy = 1'b0;
        @(negedge clk);
        chk("discard_resp", {24'd0, resp}, 32'h3C);
        chk("discard_rdy", {31'd0, resp_rdy}, 1);

        // second request during TX_LO must be ignored
        send(16'h3C3C);
        repeat (25) begin @(posedge clk); #1; end
        cmd = 16'h4003;
        snd_cmd = 1'b1;
        @(negedge clk);
        chk("ignored_trmt", {31'd0, trmt}, 0);
        chk("stable_tx_data", {24'd0, tx_data}, 32'h3C);
        @(posedge clk); #1;
        snd_cmd = 1'b0;
        wait_snt();
        respond(2, 8'hA5);
        @(negedge clk);
        chk("ignored_ack", {31'd0, ack}, 1);

        // reset in TX_LO abandons the command
        send(16'h1111);
        repeat (25) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_busy", {31'd0, busy}, 0);
        chk("mid_rst_resp", {24'd0, resp}, 0);
        chk("mid_rst_rdy", {30'd0, resp_rdy, ack}, 0);
        chk("mid_rst_pulses", {28'd0, trmt, cmd_snt, clr_rx_rdy, tmo}, 0);
        s0 = snt_cnt + tmo_cnt;
        repeat (30) @(negedge clk);
        chk("mid_rst_no_snt", snt_cnt + tmo_cnt - s0, 0);
        txn('{16'h5A5A, 3, 8'hA5, 8'hA5, 1'b1, 1'b1, 0});

        repeat (2) @(negedge clk);
        chk("queue_empty", exp_q.size(), 0);
        chk("pulse_width", viol, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
